// File: rtl/mem_responder.sv
// Word-addressed memory target with byte-lane writes behind a valid/ready request/response pair.
// Latency: resp_valid appears LATENCY+1 cycles after the request handshake; one idle cycle between transactions.
// Backpressure: the response holds until resp_ready; req_ready is high only in IDLE.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, nxt;
  logic [3:0]  cnt;
  logic        cap_wen;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wmask;
  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic        req_hs, resp_hs, enter_resp, wr_commit, in_range;
  logic        sel_wen;
  logic [31:0] sel_addr, sel_wdata, offset;
  logic [3:0]  sel_wmask;
  logic [IDXW-1:0] widx;

  assign req_hs  = req_valid & req_ready;
  assign resp_hs = resp_valid & resp_ready;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (req_hs) nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) nxt = ST_RESP;
      ST_RESP: if (resp_hs) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE) && sys_rst;
    resp_valid = (state == ST_RESP);
  end

  // With zero latency RESP is entered on the handshake edge itself, before the capture registers load.
  assign sel_wen   = (state == ST_IDLE) ? req_wen   : cap_wen;
  assign sel_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign sel_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign sel_wmask = (state == ST_IDLE) ? req_wmask : cap_wmask;

  assign offset     = sel_addr - BASE_ADDR;
  assign in_range   = (offset < SPAN);
  assign widx       = offset[IDXW+1:2];
  assign enter_resp = (state != ST_RESP) && (nxt == ST_RESP);
  assign wr_commit  = enter_resp && sel_wen && in_range;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt        <= 4'd0;
      cap_wen    <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_wmask  <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (req_hs) begin
        cap_wen   <= req_wen;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wmask <= req_wmask;
        cnt       <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_err   <= !in_range;
        resp_rdata <= (!sel_wen && in_range) ? mem[widx] : 32'd0;
      end else if (resp_hs) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

  // Storage deliberately has no reset so contents survive a reset pulse.
  always_ff @(posedge sys_clk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_wmask[i]) mem[widx][8*i +: 8] <= sel_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a LATENCY=2 instance (a_*) and a LATENCY=0 instance (b_*) on one clock.
module tb_mem_responder;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_a, a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_wmask;
  logic        rst_b, b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wmask;

  int tests = 0;
  int fails = 0;

  mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(rst_a),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A with resp_ready=1; inputs are scrambled right after acceptance.
  task automatic txn_a(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output logic [31:0] rdata, output logic err,
                       output int lat);
    int guard;
    @(negedge sys_clk);
    a_req_valid = 1'b1; a_req_wen = wen; a_req_addr = addr;
    a_req_wdata = wdata; a_req_wmask = wmask;
    guard = 0;
    while (!a_req_ready && guard < 50) begin
      @(negedge sys_clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'(guard), 32'd0);
    @(negedge sys_clk);
    a_req_valid = 1'b0; a_req_wen = ~wen; a_req_addr = ~addr;
    a_req_wdata = ~wdata; a_req_wmask = ~wmask;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      @(negedge sys_clk);
      lat++;
    end
    rdata = a_resp_rdata;
    err   = a_resp_err;
    @(negedge sys_clk);
    chk("post_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("post_resp_rdata", a_resp_rdata, 32'd0);
    chk("post_req_ready", 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, seen, accepts, resp_cnt, bad_gap, bad_data, last;

    rst_a = 1'b0; rst_b = 1'b0;
    a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wmask = '0;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
    a_resp_ready = 1'b1; b_resp_ready = 1'b1;

    repeat (3) @(negedge sys_clk);
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(a_resp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge sys_clk);
    chk("rel_req_ready", 32'(a_req_ready), 32'd1);

    // Basic write then read, LATENCY=2
    txn_a(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    txn_a(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Partial lane write and an all-zero mask
    txn_a(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
    txn_a(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b1001, rd, er, lat);
    txn_a(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    chk("partial_rdata", rd, 32'hAA22_33DD);
    txn_a(1'b1, 32'h8000_0022, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("mask0_err", 32'(er), 32'd0);
    txn_a(1'b0, 32'h8000_0021, 32'h0, 4'h0, rd, er, lat);
    chk("mask0_rdata", rd, 32'hAA22_33DD);

    // Range boundaries
    txn_a(1'b1, 32'h8000_0000, 32'h0, 4'hF, rd, er, lat);
    txn_a(1'b1, 32'h8000_03FC, 32'h5A5A_0001, 4'hF, rd, er, lat);
    txn_a(1'b0, 32'h8000_03FC, 32'h0, 4'h0, rd, er, lat);
    chk("last_word_rdata", rd, 32'h5A5A_0001);
    chk("last_word_err", 32'(er), 32'd0);
    txn_a(1'b0, 32'h8000_0400, 32'h0, 4'h0, rd, er, lat);
    chk("oor_hi_err", 32'(er), 32'd1);
    chk("oor_hi_rdata", rd, 32'd0);
    txn_a(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
    chk("oor_lo_err", 32'(er), 32'd1);
    chk("oor_lo_rdata", rd, 32'd0);
    txn_a(1'b1, 32'h8000_0400, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_lat", 32'(lat), 32'd3);
    txn_a(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("oor_wr_word0", rd, 32'd0);
    txn_a(1'b0, 32'h8000_03FC, 32'h0, 4'h0, rd, er, lat);
    chk("oor_wr_lastword", rd, 32'h5A5A_0001);

    // Response backpressure for 5 cycles
    a_resp_ready = 1'b0;
    @(negedge sys_clk);
    a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 32'h8000_0010;
    @(negedge sys_clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(a_resp_valid), 32'd1);
      chk("bp_rdata", a_resp_rdata, 32'hDEAD_BEEF);
      chk("bp_req_ready", 32'(a_req_ready), 32'd0);
      @(negedge sys_clk);
    end
    a_resp_ready = 1'b1;
    @(negedge sys_clk);
    chk("bp_done_valid", 32'(a_resp_valid), 32'd0);
    chk("bp_done_req_ready", 32'(a_req_ready), 32'd1);

    // Reset while a write waits: no response, no commit
    a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 32'h8000_0000;
    a_req_wdata = 32'h1234_5678; a_req_wmask = 4'hF;
    @(negedge sys_clk);
    a_req_valid = 1'b0;
    rst_a = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (a_resp_valid) seen++;
    end
    chk("midrst_req_ready", 32'(a_req_ready), 32'd0);
    chk("midrst_rdata", a_resp_rdata, 32'd0);
    rst_a = 1'b1;
    @(negedge sys_clk);
    if (a_resp_valid) seen++;
    chk("midrst_no_resp", 32'(seen), 32'd0);
    chk("midrst_req_ready_rel", 32'(a_req_ready), 32'd1);
    txn_a(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_word0", rd, 32'd0);
    txn_a(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("storage_kept", rd, 32'hDEAD_BEEF);

    // LATENCY=0 instance
    @(negedge sys_clk);
    b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_addr = 32'h8000_0008;
    b_req_wdata = 32'h0BAD_F00D; b_req_wmask = 4'hF;
    chk("b_idle_ready", 32'(b_req_ready), 32'd1);
    @(negedge sys_clk);
    b_req_valid = 1'b0;
    chk("b_wr_valid", 32'(b_resp_valid), 32'd1);
    chk("b_wr_err", 32'(b_resp_err), 32'd0);
    @(negedge sys_clk);
    chk("b_wr_done", 32'(b_resp_valid), 32'd0);

    b_req_wen = 1'b0; b_req_wdata = 32'h0; b_req_wmask = 4'h0;
    accepts = 0; resp_cnt = 0; bad_gap = 0; bad_data = 0; last = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge sys_clk);
      b_req_valid = (accepts < 10);
      if (b_resp_valid) begin
        resp_cnt++;
        if (b_resp_rdata !== 32'h0BAD_F00D || b_resp_err !== 1'b0) bad_data++;
      end
      if (b_req_valid && b_req_ready) begin
        if (accepts > 0 && cyc - last != 2) bad_gap++;
        last = cyc;
        accepts++;
      end
    end
    chk("b2b_accepts", 32'(accepts), 32'd10);
    chk("b2b_responses", 32'(resp_cnt), 32'd10);
    chk("b2b_bad_gap", 32'(bad_gap), 32'd0);
    chk("b2b_bad_data", 32'(bad_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, range 0..15: wait cycles between request acceptance and response.
REQ-004 SHALL have port sys_clk input 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst input 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid input 1: the initiator presents a request.
REQ-007 SHALL have port req_ready output 1: the responder can accept a request.
REQ-008 SHALL have port req_wen input 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr input 32: byte address; bits [1:0] are ignored for storage indexing.
REQ-010 SHALL have port req_wdata input 32: write data, lane-aligned.
REQ-011 SHALL have port req_wmask input 4: byte-lane write enables; bit i enables req_wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid output 1: a response is presented.
REQ-013 SHALL have port resp_ready input 1: the initiator accepts the response.
REQ-014 SHALL have port resp_rdata output 32: read data (0 for writes and errors).
REQ-015 SHALL have port resp_err output 1: the address was out of range.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; the request handshake is req_valid & req_ready on a rising edge.
REQ-018 On handshake, req_wen, req_addr, req_wdata and req_wmask SHALL be captured into internal registers; later input changes SHALL have no effect on that transaction.
REQ-019 On handshake, if LATENCY=0: IDLE->RESP; otherwise IDLE->WAIT, with a 4-bit counter loaded with LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; on the cycle it equals 0, WAIT->RESP.
REQ-021 Address decode: offset = addr - BASE_ADDR (32-bit, wraps); in range iff offset < DEPTH_WORDS*4; word index = offset[31:2].
REQ-022 On entry to RESP, an in-range write SHALL update only the lanes enabled by the captured mask; a mask of 4'b0000 SHALL write nothing but still respond.
REQ-023 On entry to RESP, an in-range read SHALL register the full addressed word onto resp_rdata.
REQ-024 For an out-of-range request, resp_err SHALL be 1, resp_rdata SHALL be 0 and storage SHALL be unchanged.
REQ-025 For a write, resp_rdata SHALL be 0 and resp_err SHALL follow REQ-024.
REQ-026 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until the handshake.
REQ-027 On resp_valid & resp_ready, RESP->IDLE; resp_valid, resp_rdata and resp_err SHALL clear to 0 the next cycle.
REQ-028 Back-to-back transactions SHALL incur one idle cycle; minimum spacing between acceptances is LATENCY+2 cycles.
REQ-029 A read of a word written by an earlier transaction SHALL return the updated value, since writes commit before the write's response handshake.
REQ-030 Latency, measured as the number of cycles from the request handshake edge to the first cycle with resp_valid=1, SHALL be exactly LATENCY+1.
REQ-031 resp_ready high while not in RESP SHALL have no effect.

Reset
REQ-032 While sys_rst=0: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, all captured request registers=0.
REQ-033 req_ready SHALL rise in the first cycle after sys_rst deasserts.
REQ-034 Reset asserted during WAIT or RESP SHALL abort the transaction without emitting a response; a write not yet committed SHALL not be committed.
REQ-035 Storage contents SHALL not be cleared by reset.

Verification
REQ-036 LATENCY=2: write addr 8000_0010, data DEADBEEF, mask F; then read 8000_0010 -> resp_rdata=DEADBEEF, resp_err=0, resp_valid exactly 3 cycles after each acceptance.
REQ-037 Partial write: preload 8000_0020 = 11223344; write data AABBCCDD, mask 4'b1001 -> a subsequent read returns AA2233DD.
REQ-038 Out of range: read 8000_0400 (DEPTH 256) and read 7FFF_FFFC -> resp_err=1, resp_rdata=0; a write to 8000_0400 leaves all words unchanged.
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready stays 0; after the handshake, req_ready=1 the next cycle.
REQ-040 Reset mid-WAIT during a write of 12345678 to 8000_0000 (previously 0) -> resp_valid never asserts, req_ready=1 after release, and a subsequent read returns 00000000.
REQ-041 LATENCY=0 build: a read responds with resp_valid in the cycle after acceptance; 10 back-to-back reads with resp_ready held 1 complete with one acceptance every 2 cycles.
